// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and writer state encoding, used by both the
// writer and the display-side reader so the two ends agree on box placement.
`default_nettype none

package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fb_state_t;

  localparam int X_BEGIN   = 270;
  localparam int Y_BEGIN   = 190;
  localparam int X_BOXSIZE = 100;
  localparam int Y_BOXSIZE = 100;
  localparam int FB_STRIDE = 255;

endpackage

`default_nettype wire

// File: rtl/fb_addr_gen.sv
// Column/row walker for the box; produces col + STRIDE*row using a row_base
// accumulator instead of a multiplier.
`default_nettype none

module fb_addr_gen #(
  parameter int BOX_W  = 100,
  parameter int BOX_H  = 100,
  parameter int STRIDE = 255,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int COL_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int ROW_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BOX_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(BOX_H - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

  logic [COL_W-1:0]  col, col_cur, col_next;
  logic [ROW_W-1:0]  row, row_cur, row_next;
  logic [ADDR_W-1:0] row_base, base_cur, base_next;

  // clear rewinds to (0,0) first so clear+advance lands on the pixel after origin
  always_comb begin
    col_cur   = clear ? '0 : col;
    row_cur   = clear ? '0 : row;
    base_cur  = clear ? '0 : row_base;
    col_next  = col_cur;
    row_next  = row_cur;
    base_next = base_cur;
    if (advance) begin
      if (col_cur == COL_LAST) begin
        col_next  = '0;
        row_next  = row_cur + ROW_W'(1);
        base_next = base_cur + STEP;
      end else begin
        col_next  = col_cur + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      col      <= col_next;
      row      <= row_next;
      row_base <= base_next;
    end
  end

  assign addr = row_base + ADDR_W'(col);
  assign last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_fb_writer.sv
// Framebuffer writer: turns an SOF-framed valid/ready pixel stream into
// registered single-port RAM writes at col + STRIDE*row.
`default_nettype none

module vga_fb_writer
  import vga_pkg::*;
#(
  parameter int BOX_W  = X_BOXSIZE,
  parameter int BOX_H  = Y_BOXSIZE,
  parameter int STRIDE = FB_STRIDE,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_sof,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_drop,
  output logic              err_resync
);

  localparam bit SINGLE = (BOX_W == 1) && (BOX_H == 1);

  fb_state_t         state, state_next;
  logic              accept;
  logic              gen_clear, gen_advance, gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic              wr_en_d, drop_d, resync_d, done_d;
  logic [ADDR_W-1:0] wr_addr_d;

  assign s_ready = rst && (state != DONE);
  assign accept  = s_valid && s_ready;

  fb_addr_gen #(
    .BOX_W  (BOX_W),
    .BOX_H  (BOX_H),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (gen_clear),
    .advance (gen_advance),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = gen_addr;
    drop_d      = 1'b0;
    resync_d    = 1'b0;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            gen_clear   = 1'b1;
            gen_advance = 1'b1;
            done_d      = SINGLE;
            state_next  = SINGLE ? DONE : WRITE;
          end else begin
            drop_d      = 1'b1;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          wr_en_d     = 1'b1;
          gen_advance = 1'b1;
          if (s_sof) begin
            // restart the frame at origin; this beat is pixel (0,0)
            resync_d   = 1'b1;
            wr_addr_d  = '0;
            gen_clear  = 1'b1;
            done_d     = SINGLE;
            state_next = SINGLE ? DONE : WRITE;
          end else if (gen_last) begin
            done_d     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
      err_resync <= 1'b0;
    end else begin
      wr_en      <= wr_en_d;
      if (wr_en_d) begin
        wr_addr  <= wr_addr_d;
        wr_data  <= s_data;
      end
      busy       <= (state_next == WRITE);
      frame_done <= done_d;
      err_drop   <= drop_d;
      err_resync <= resync_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: 100x100 box (stride 255) plus a 1x1 box.
`default_nettype none

module tb_vga_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0, s_sof = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, wr_en, busy, frame_done, err_drop, err_resync;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  logic        s1_valid = 1'b0, s1_sof = 1'b0;
  logic [7:0]  s1_data = 8'h00;
  logic        s1_ready, wr1_en, busy1, frame_done1, err_drop1, err_resync1;
  logic [3:0]  wr1_addr;
  logic [7:0]  wr1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_writer #(.BOX_W(100), .BOX_H(100), .STRIDE(255), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .err_drop(err_drop), .err_resync(err_resync)
  );

  vga_fb_writer #(.BOX_W(1), .BOX_H(1), .STRIDE(1), .ADDR_W(4)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
    .s_sof(s1_sof), .wr_en(wr1_en), .wr_addr(wr1_addr), .wr_data(wr1_data),
    .busy(busy1), .frame_done(frame_done1), .err_drop(err_drop1), .err_resync(err_resync1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return 32'((i % 100) + 255 * (i / 100));
  endfunction

  task automatic chk_write(input string tag, input int pos, input logic [7:0] d, input bit last);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, ".addr"}, 32'(wr_addr), exp_addr(pos));
    chk({tag, ".data"}, 32'(wr_data), 32'(d));
    chk({tag, ".done"}, 32'(frame_done), 32'(last));
    chk({tag, ".busy"}, 32'(busy), 32'(!last));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".data"}, 32'(wr_data), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(frame_done), 32'd0);
    chk({tag, ".drop"}, 32'(err_drop), 32'd0);
    chk({tag, ".resync"}, 32'(err_resync), 32'd0);
    chk({tag, ".ready"}, 32'(s_ready), 32'd0);
  endtask

  initial begin
    int idx;
    int budget;
    bit v;

    // reset state
    rst = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset.ready1", 32'(s1_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("release.ready", 32'(s_ready), 32'd1);

    // full frame, s_valid held high
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'b1; s_sof = (i == 0); s_data = 8'(i);
      step();
      chk_write("stream", i, 8'(i), i == 9999);
      chk("stream.ready", 32'(s_ready), 32'(i != 9999));
    end
    s_valid = 1'b0; s_sof = 1'b0;
    step();
    chk("post.wr_en", 32'(wr_en), 32'd0);
    chk("post.done", 32'(frame_done), 32'd0);
    chk("post.ready", 32'(s_ready), 32'd1);
    chk("post.busy", 32'(busy), 32'd0);

    // full frame with random valid gaps
    idx = 0;
    budget = 0;
    while (idx < 10000 && budget < 40000) begin
      v = 1'($urandom_range(0, 1));
      s_valid = v; s_sof = (idx == 0); s_data = 8'(idx ^ 8'h5A);
      step();
      budget++;
      if (v) begin
        chk_write("gap", idx, 8'(idx ^ 8'h5A), idx == 9999);
        idx++;
      end else begin
        chk("gap.idle_wr_en", 32'(wr_en), 32'd0);
        chk("gap.idle_done", 32'(frame_done), 32'd0);
      end
    end
    chk("gap.beats", 32'(idx), 32'd10000);
    s_valid = 1'b0; s_sof = 1'b0;
    step();

    // non-SOF beats in IDLE are dropped
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_sof = 1'b0; s_data = 8'hE0 + 8'(i);
      step();
      chk("drop.pulse", 32'(err_drop), 32'd1);
      chk("drop.wr_en", 32'(wr_en), 32'd0);
      chk("drop.busy", 32'(busy), 32'd0);
    end
    s_valid = 1'b0;
    step();
    chk("drop.clear", 32'(err_drop), 32'd0);

    // SOF at beat 150 restarts the frame
    for (int i = 0; i < 150; i++) begin
      s_valid = 1'b1; s_sof = (i == 0); s_data = 8'(i);
      step();
      chk("pre_resync.addr", 32'(wr_addr), exp_addr(i));
      chk("pre_resync.resync", 32'(err_resync), 32'd0);
    end
    for (int j = 0; j < 10000; j++) begin
      s_valid = 1'b1; s_sof = (j == 0); s_data = 8'(j + 3);
      step();
      chk_write("resync", j, 8'(j + 3), j == 9999);
      chk("resync.pulse", 32'(err_resync), 32'(j == 0));
    end
    s_valid = 1'b0; s_sof = 1'b0;
    step();

    // reset in the middle of a frame
    for (int i = 0; i < 5000; i++) begin
      s_valid = 1'b1; s_sof = (i == 0); s_data = 8'(i);
      step();
      chk("abort.addr", 32'(wr_addr), exp_addr(i));
    end
    rst = 1'b0;
    step();
    chk_all_zero("abort_rst1");
    step();
    chk_all_zero("abort_rst2");
    rst = 1'b1; s_valid = 1'b0;
    step();
    chk("abort.no_done", 32'(frame_done), 32'd0);
    chk("abort.ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'hAA;
    step();
    chk_write("newframe0", 0, 8'hAA, 1'b0);
    s_sof = 1'b0; s_data = 8'hBB;
    step();
    chk_write("newframe1", 1, 8'hBB, 1'b0);
    s_valid = 1'b0;
    step();

    // 1x1 box: SOF goes straight to DONE
    s1_valid = 1'b1; s1_sof = 1'b1; s1_data = 8'h5C;
    step();
    chk("one.wr_en", 32'(wr1_en), 32'd1);
    chk("one.addr", 32'(wr1_addr), 32'd0);
    chk("one.data", 32'(wr1_data), 32'h5C);
    chk("one.done", 32'(frame_done1), 32'd1);
    chk("one.ready", 32'(s1_ready), 32'd0);
    chk("one.busy", 32'(busy1), 32'd0);
    s1_valid = 1'b0; s1_sof = 1'b0;
    step();
    chk("one.done_clear", 32'(frame_done1), 32'd0);
    chk("one.wr_clear", 32'(wr1_en), 32'd0);
    chk("one.ready_back", 32'(s1_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
